// File: rtl/ps2_entry_ctrl_if.sv
// rtl/ps2_entry_ctrl_if.sv - token output handshake between keyboard front-end and ALU side
interface ps2_entry_ctrl_if #(
    parameter int VAL_W = 10
);
    logic             out_valid;
    logic             out_ready;
    logic             out_is_op;
    logic [1:0]       out_op;
    logic [VAL_W-1:0] out_value;

    modport master (
        output out_valid,
        output out_is_op,
        output out_op,
        output out_value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_is_op,
        input  out_op,
        input  out_value,
        output out_ready
    );
endinterface

// File: rtl/ps2_entry_ctrl.sv
// rtl/ps2_entry_ctrl.sv - PS/2 set-2 receiver, scan-code decode and decimal operand entry
module ps2_entry_ctrl #(
    parameter int NUM_DIGITS  = 3,
    parameter int VAL_W       = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               kb_clk_sync,
    input  logic                               kb_data_sync,
    ps2_entry_ctrl_if.master                   tok,
    output logic [4*NUM_DIGITS-1:0]            entry_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    entry_len,
    output logic                               frame_err,
    output logic                               overrun
);
    localparam int LEN_W = $clog2(NUM_DIGITS + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} pstate_t;
    typedef enum logic [2:0] {A_NONE, A_DIGIT, A_OP, A_ENTER, A_BKSP, A_ESC} act_t;

    logic            kb_clk_q;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [TO_W-1:0] to_cnt;
    logic            code_stb;
    logic [7:0]      code;
    logic            kb_fall;

    pstate_t         pstate;
    act_t            act;
    logic [3:0]      act_val;
    logic            pend_valid;
    logic [1:0]      pend_op;
    logic [VAL_W-1:0] bin;
    logic            busy;

    assign kb_fall = kb_clk_q & ~kb_clk_sync;
    assign busy    = tok.out_valid | pend_valid;

    // Frame receiver: shift bits on kb_clk falling edges, validate on the 11th, drop stale partial frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_clk_q  <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            code_stb  <= 1'b0;
            code      <= '0;
            frame_err <= 1'b0;
        end else begin
            kb_clk_q  <= kb_clk_sync;
            code_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (kb_fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    // shreg holds start in bit 0, data in 8:1, parity in 9; stop is on the line now
                    if (!shreg[0] && (^shreg[9:1]) && kb_data_sync) begin
                        code_stb <= 1'b1;
                        code     <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {kb_data_sync, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Translate a received code into a key action according to the current prefix state
    always_comb begin
        act     = A_NONE;
        act_val = 4'd0;
        if (code_stb) begin
            case (pstate)
                S_IDLE: begin
                    case (code)
                        8'h45, 8'h70: begin act = A_DIGIT; act_val = 4'd0; end
                        8'h16, 8'h69: begin act = A_DIGIT; act_val = 4'd1; end
                        8'h1E, 8'h72: begin act = A_DIGIT; act_val = 4'd2; end
                        8'h26, 8'h7A: begin act = A_DIGIT; act_val = 4'd3; end
                        8'h25, 8'h6B: begin act = A_DIGIT; act_val = 4'd4; end
                        8'h2E, 8'h73: begin act = A_DIGIT; act_val = 4'd5; end
                        8'h36, 8'h74: begin act = A_DIGIT; act_val = 4'd6; end
                        8'h3D, 8'h6C: begin act = A_DIGIT; act_val = 4'd7; end
                        8'h3E, 8'h75: begin act = A_DIGIT; act_val = 4'd8; end
                        8'h46, 8'h7D: begin act = A_DIGIT; act_val = 4'd9; end
                        8'h79:        begin act = A_OP;    act_val = 4'd0; end
                        8'h7B:        begin act = A_OP;    act_val = 4'd1; end
                        8'h7C:        begin act = A_OP;    act_val = 4'd2; end
                        8'h5A:        act = A_ENTER;
                        8'h66:        act = A_BKSP;
                        8'h76:        act = A_ESC;
                        default:      act = A_NONE;
                    endcase
                end
                S_EXT: begin
                    if (code == 8'h5A) begin
                        act = A_ENTER;
                    end else if (code == 8'h4A) begin
                        act     = A_OP;
                        act_val = 4'd3;
                    end
                end
                default: act = A_NONE;
            endcase
        end
    end

    // BCD entry to binary, most significant digit first
    always_comb begin
        bin = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            bin = bin * VAL_W'(10) + VAL_W'(entry_bcd[4*i +: 4]);
        end
    end

    // Prefix FSM, entry register and token output with one-deep pending operator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate        <= S_IDLE;
            entry_bcd     <= '0;
            entry_len     <= '0;
            overrun       <= 1'b0;
            pend_valid    <= 1'b0;
            pend_op       <= '0;
            tok.out_valid <= 1'b0;
            tok.out_is_op <= 1'b0;
            tok.out_op    <= '0;
            tok.out_value <= '0;
        end else begin
            if (code_stb) begin
                case (pstate)
                    S_IDLE:  pstate <= (code == 8'hF0) ? S_BRK :
                                       (code == 8'hE0) ? S_EXT : S_IDLE;
                    S_EXT:   pstate <= (code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: pstate <= S_IDLE;
                endcase
            end

            // A transfer either retires the token or promotes the pending operator
            if (tok.out_valid && tok.out_ready) begin
                if (pend_valid) begin
                    tok.out_is_op <= 1'b1;
                    tok.out_op    <= pend_op;
                    tok.out_value <= '0;
                    pend_valid    <= 1'b0;
                end else begin
                    tok.out_valid <= 1'b0;
                end
            end

            case (act)
                A_DIGIT: begin
                    if (entry_len < LEN_W'(NUM_DIGITS)) begin
                        entry_bcd <= (entry_bcd << 4) | BCD_W'(act_val);
                        entry_len <= entry_len + 1'b1;
                    end
                end
                A_BKSP: begin
                    if (entry_len != '0) begin
                        entry_bcd <= entry_bcd >> 4;
                        entry_len <= entry_len - 1'b1;
                    end
                end
                A_ESC: begin
                    entry_bcd <= '0;
                    entry_len <= '0;
                    overrun   <= 1'b0;
                end
                A_ENTER, A_OP: begin
                    if (act == A_OP || entry_len != '0) begin
                        entry_bcd <= '0;
                        entry_len <= '0;
                        if (busy) begin
                            overrun <= 1'b1;
                        end else if (entry_len != '0) begin
                            tok.out_valid <= 1'b1;
                            tok.out_is_op <= 1'b0;
                            tok.out_op    <= '0;
                            tok.out_value <= bin;
                            if (act == A_OP) begin
                                pend_valid <= 1'b1;
                                pend_op    <= act_val[1:0];
                            end
                        end else begin
                            tok.out_valid <= 1'b1;
                            tok.out_is_op <= 1'b1;
                            tok.out_op    <= act_val[1:0];
                            tok.out_value <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// tb/tb_ps2_entry_ctrl.sv - scoreboard bench for ps2_entry_ctrl
module tb_ps2_entry_ctrl;
    localparam int ND = 3;
    localparam int VW = 10;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kb_clk_sync = 1'b1;
    logic kb_data_sync = 1'b1;
    logic [4*ND-1:0] entry_bcd;
    logic [1:0] entry_len;
    logic frame_err;
    logic overrun;

    ps2_entry_ctrl_if #(.VAL_W(VW)) tok();

    ps2_entry_ctrl #(.NUM_DIGITS(ND), .VAL_W(VW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .kb_clk_sync(kb_clk_sync),
        .kb_data_sync(kb_data_sync),
        .tok(tok),
        .entry_bcd(entry_bcd),
        .entry_len(entry_len),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_op;
        int op;
        int value;
    } tok_t;

    int compared = 0;
    int mismatched = 0;
    int err_seen = 0;
    int err_exp = 0;
    tok_t exp_q[$];
    int model_d[$];
    logic [7:0] top_row [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] keypad  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Token monitor: every transfer is popped from the scoreboard and compared
    always @(negedge clk) begin
        tok_t e;
        if (!rst && frame_err) err_seen++;
        if (!rst && tok.out_valid && tok.out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_token: got is_op=%0d op=%0d value=%0d, expected no token",
                         tok.out_is_op, tok.out_op, tok.out_value);
            end else begin
                e = exp_q.pop_front();
                check("token_is_op", int'(tok.out_is_op), int'(e.is_op));
                if (e.is_op) check("token_op", int'(tok.out_op), e.op);
                else         check("token_value", int'(tok.out_value), e.value);
            end
        end
    end

    function automatic int model_bcd();
        int r = 0;
        for (int i = 0; i < model_d.size(); i++)
            r = r | (model_d[i] << (4 * (model_d.size() - 1 - i)));
        return r;
    endfunction

    task automatic model_flush();
        tok_t t;
        int v = 0;
        if (model_d.size() > 0) begin
            foreach (model_d[i]) v = v * 10 + model_d[i];
            t.is_op = 1'b0; t.op = 0; t.value = v;
            exp_q.push_back(t);
            model_d.delete();
        end
    endtask

    task automatic model_op(input int o);
        tok_t t;
        model_flush();
        t.is_op = 1'b1; t.op = o; t.value = 0;
        exp_q.push_back(t);
    endtask

    task automatic model_key(input logic [7:0] c, input bit ext);
        if (ext) begin
            if (c == 8'h5A) model_flush();
            else if (c == 8'h4A) model_op(3);
        end else begin
            for (int i = 0; i < 10; i++)
                if ((top_row[i] == c || keypad[i] == c) && model_d.size() < ND) model_d.push_back(i);
            case (c)
                8'h79: model_op(0);
                8'h7B: model_op(1);
                8'h7C: model_op(2);
                8'h5A: model_flush();
                8'h66: if (model_d.size() > 0) void'(model_d.pop_back());
                8'h76: model_d.delete();
                default: ;
            endcase
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^c) ^ bad_par, c, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kb_data_sync = bits[i];
            tick(4);
            kb_clk_sync = 1'b0;
            tick(5);
            kb_clk_sync = 1'b1;
            tick(1);
        end
        kb_data_sync = 1'b1;
        tick(12);
    endtask

    task automatic press_raw(input logic [7:0] c, input bit ext);
        if (ext) send_frame(8'hE0, 1'b0, 11);
        send_frame(c, 1'b0, 11);
        if (ext) send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(c, 1'b0, 11);
    endtask

    task automatic key(input logic [7:0] c, input bit ext);
        model_key(c, ext);
        press_raw(c, ext);
    endtask

    task automatic check_entry(input string name);
        check({name, "_len"}, int'(entry_len), model_d.size());
        check({name, "_bcd"}, int'(entry_bcd), model_bcd());
    endtask

    initial begin
        int r;
        int d;
        tok.out_ready = 1'b1;
        tick(3);
        check("reset_out_valid", int'(tok.out_valid), 0);
        check("reset_entry_len", int'(entry_len), 0);
        check("reset_entry_bcd", int'(entry_bcd), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        tick(3);

        key(8'h16, 0); check_entry("k1");
        key(8'h1E, 0); check_entry("k12");
        key(8'h26, 0); check_entry("k123");
        key(8'h5A, 0); check_entry("k123_enter");

        key(8'h69, 0); key(8'h72, 0); key(8'h4A, 1);
        check_entry("kp12_div");

        for (int i = 0; i < 4; i++) key(8'h46, 0);
        check_entry("k9999");
        key(8'h66, 0); check_entry("k_bksp");
        key(8'h2E, 0); check_entry("k995");
        key(8'h5A, 0);

        send_frame(8'h16, 1'b1, 11);
        err_exp++;
        check("parity_err_count", err_seen, err_exp);
        check_entry("after_parity");
        key(8'h16, 0); check_entry("after_good");
        key(8'h76, 0);

        send_frame(8'h45, 1'b0, 5);
        tick(TO + 20);
        err_exp++;
        check("timeout_err_count", err_seen, err_exp);
        key(8'h45, 0); check_entry("after_timeout");
        key(8'h76, 0);

        tok.out_ready = 1'b0;
        key(8'h3D, 0); key(8'h5A, 0);
        check("held_valid", int'(tok.out_valid), 1);
        check("held_value", int'(tok.out_value), 7);
        press_raw(8'h3E, 0); press_raw(8'h5A, 0);
        check("overrun_set", int'(overrun), 1);
        check("held_value_after_drop", int'(tok.out_value), 7);
        check_entry("after_drop");
        key(8'h76, 0);
        check("overrun_cleared", int'(overrun), 0);
        tok.out_ready = 1'b1;
        tick(3);

        tok.out_ready = 1'b0;
        press_raw(8'h16, 0); press_raw(8'h5A, 0);
        check("pre_reset_valid", int'(tok.out_valid), 1);
        rst = 1'b1;
        tick(1);
        check("mid_reset_valid", int'(tok.out_valid), 0);
        rst = 1'b0;
        tok.out_ready = 1'b1;
        tick(5);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 9);
            if (r < 50)      key($urandom_range(0, 1) ? top_row[d] : keypad[d], 0);
            else if (r < 62) key(8'h5A, 0);
            else if (r < 72) key(r[0] ? 8'h79 : (r[1] ? 8'h7B : 8'h7C), 0);
            else if (r < 82) key(8'h66, 0);
            else if (r < 85) key(8'h76, 0);
            else if (r < 90) key(r[0] ? 8'h1C : 8'h4A, 0);
            else if (r < 95) key(r[0] ? 8'h5A : 8'h4A, 1);
            else             key(8'h6B, 1);
            check_entry("rand");
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("tokens_left", exp_q.size(), 0);
        check("frame_err_total", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
